cpu_mem_arbiter: RTL and testbench

//  Shares one memory port between the CPU instruction-fetch channel and data (load/store) channel.

---
 rtl/cpu_bus_pkg.sv | 19 +
 rtl/arb_pick2.sv | 29 ++
 rtl/cpu_mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU-side bus blocks.
//   state_e           : one-hot FSM encoding used by the memory arbiter
//   OWN_INST/OWN_DATA : requester identity (also the bit index in grant vectors)
//   PRIO_FIXED/PRIO_RR: arbitration policy selectors
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_ISSUE = 3'b010,
    ST_RWAIT = 3'b100
  } state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

endpackage

// File: rtl/arb_pick2.sv
// Two-way combinational arbiter.
//   req  : request vector, bit OWN_INST / bit OWN_DATA
//   last : owner of the previous grant (used only in round-robin mode)
//   mode : 0 = fixed priority (bit 1 wins), 1 = round-robin on conflict
//   gnt  : one-hot grant, all zero when nothing is requested
module arb_pick2
  import cpu_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       mode,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        // Round-robin hands the conflict to whoever did not win last time.
        if (mode && (last == OWN_DATA)) gnt = 2'b01;
        else                            gnt = 2'b10;
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one memory port between the CPU fetch channel and load/store channel.
//   clk, rst           : clock, asynchronous active-low reset
//   inst_*             : fetch request (addr/valid/ready) and response (rdata/rvalid/rready)
//   data_*             : load/store request (addr/read/write/wdata/wstrb/ready) and response
//   mem_*              : single memory request channel and its read-response channel
//   conflict_cnt       : free-running count of IDLE cycles with both sides pending
// One transaction is outstanding at a time; the read response is routed to its owner only.
module cpu_mem_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     inst_addr,
  input  logic                  inst_req_valid,
  output logic                  inst_req_ready,
  output logic [DATA_W-1:0]     inst_rdata,
  output logic                  inst_rvalid,
  input  logic                  inst_rready,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic                  data_read,
  input  logic                  data_write,
  input  logic [DATA_W-1:0]     data_wdata,
  input  logic [DATA_W/8-1:0]   data_wstrb,
  output logic                  data_req_ready,
  output logic [DATA_W-1:0]     data_rdata,
  output logic                  data_rvalid,
  input  logic                  data_rready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic                  mem_req_ready,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  mem_rready,
  output logic [31:0]           conflict_cnt
);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic                  wr_q, wr_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic [31:0]           cnt_q, cnt_d;

  logic                  inst_pend, data_pend;
  logic [1:0]            gnt;
  logic                  mode;

  assign inst_pend = inst_req_valid;
  assign data_pend = data_read | data_write;
  assign mode      = (PRIO_MODE == PRIO_RR);

  arb_pick2 u_pick (
    .req  ({data_pend, inst_pend}),
    .last (last_q),
    .mode (mode),
    .gnt  (gnt)
  );

  // Request latches feed the memory channel directly so it stays stable until accepted.
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_wstrb    = wstrb_q;
  assign conflict_cnt = cnt_q;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    wr_d           = wr_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    inst_req_ready = 1'b0;
    data_req_ready = 1'b0;
    inst_rvalid    = 1'b0;
    inst_rdata     = '0;
    data_rvalid    = 1'b0;
    data_rdata     = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_rready     = 1'b0;

    // Wraps naturally at 2^32.
    cnt_d = cnt_q + ((state_q == ST_IDLE && inst_pend && data_pend) ? 32'd1 : 32'd0);

    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          state_d = ST_ISSUE;
          if (gnt[1]) begin
            owner_d        = OWN_DATA;
            last_d         = OWN_DATA;
            addr_d         = data_addr;
            wr_d           = data_write;   // read+write together is a write
            wdata_d        = data_wdata;
            wstrb_d        = data_wstrb;
            // Ready is gated by rst so nothing handshakes while reset is held.
            data_req_ready = rst;
          end else begin
            owner_d        = OWN_INST;
            last_d         = OWN_INST;
            addr_d         = inst_addr;
            wr_d           = 1'b0;
            wdata_d        = '0;
            wstrb_d        = '0;
            inst_req_ready = rst;
          end
        end
      end

      ST_ISSUE: begin
        mem_read  = ~wr_q;
        mem_write = wr_q;
        if (mem_req_ready) state_d = wr_q ? ST_IDLE : ST_RWAIT;
      end

      ST_RWAIT: begin
        if (owner_q == OWN_DATA) begin
          mem_rready  = data_rready;
          data_rvalid = mem_rvalid;
          data_rdata  = mem_rdata;
        end else begin
          mem_rready  = inst_rready;
          inst_rvalid = mem_rvalid;
          inst_rdata  = mem_rdata;
        end
        if (mem_rvalid && mem_rready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_INST;
      last_q  <= OWN_INST;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr;
  logic        inst_req_valid, inst_rready;
  logic [31:0] data_addr, data_wdata;
  logic        data_read, data_write, data_rready;
  logic [3:0]  data_wstrb;
  logic        mem_req_ready, mem_rvalid;
  logic [31:0] mem_rdata;

  // round-robin instance outputs
  logic        inst_req_ready, inst_rvalid, data_req_ready, data_rvalid;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata, conflict_cnt;
  logic        mem_read, mem_write, mem_rready;
  logic [3:0]  mem_wstrb;

  // fixed-priority instance outputs
  logic        fx_inst_req_ready, fx_inst_rvalid, fx_data_req_ready, fx_data_rvalid;
  logic [31:0] fx_inst_rdata, fx_data_rdata, fx_mem_addr, fx_mem_wdata, fx_conflict_cnt;
  logic        fx_mem_read, fx_mem_write, fx_mem_rready;
  logic [3:0]  fx_mem_wstrb;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(1)) u_rr (
    .clk(clk), .rst(rst),
    .inst_addr(inst_addr), .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
    .inst_rdata(inst_rdata), .inst_rvalid(inst_rvalid), .inst_rready(inst_rready),
    .data_addr(data_addr), .data_read(data_read), .data_write(data_write),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_req_ready(data_req_ready),
    .data_rdata(data_rdata), .data_rvalid(data_rvalid), .data_rready(data_rready),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_req_ready(mem_req_ready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
    .conflict_cnt(conflict_cnt)
  );

  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(0)) u_fx (
    .clk(clk), .rst(rst),
    .inst_addr(inst_addr), .inst_req_valid(inst_req_valid), .inst_req_ready(fx_inst_req_ready),
    .inst_rdata(fx_inst_rdata), .inst_rvalid(fx_inst_rvalid), .inst_rready(inst_rready),
    .data_addr(data_addr), .data_read(data_read), .data_write(data_write),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_req_ready(fx_data_req_ready),
    .data_rdata(fx_data_rdata), .data_rvalid(fx_data_rvalid), .data_rready(data_rready),
    .mem_addr(fx_mem_addr), .mem_read(fx_mem_read), .mem_write(fx_mem_write),
    .mem_wdata(fx_mem_wdata), .mem_wstrb(fx_mem_wstrb), .mem_req_ready(mem_req_ready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_rready(fx_mem_rready),
    .conflict_cnt(fx_conflict_cnt)
  );

  task automatic clear_inputs();
    inst_addr = '0; inst_req_valid = 0; inst_rready = 0;
    data_addr = '0; data_read = 0; data_write = 0; data_wdata = '0; data_wstrb = '0;
    data_rready = 0; mem_req_ready = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    inst_req_valid = 1; data_write = 1; data_addr = 32'h44; mem_rvalid = 1;
    #1;
    checks++; if (inst_req_ready !== 1'b0) begin failures++; $display("FAIL rst_inst_ready got=%0h exp=0", inst_req_ready); end
    checks++; if (data_req_ready !== 1'b0) begin failures++; $display("FAIL rst_data_ready got=%0h exp=0", data_req_ready); end
    checks++; if ({mem_read, mem_write, mem_rready} !== 3'b000) begin failures++; $display("FAIL rst_mem_ctl got=%0b exp=000", {mem_read, mem_write, mem_rready}); end
    checks++; if ({inst_rvalid, data_rvalid} !== 2'b00) begin failures++; $display("FAIL rst_rvalid got=%0b exp=00", {inst_rvalid, data_rvalid}); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin failures++; $display("FAIL rst_mem_bus got=%h/%h/%h exp=0/0/0", mem_addr, mem_wdata, mem_wstrb); end
    checks++; if (conflict_cnt !== 32'h0) begin failures++; $display("FAIL rst_conflict_cnt got=%0d exp=0", conflict_cnt); end
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fetch();
    do_reset();
    @(negedge clk);
    inst_req_valid = 1; inst_addr = 32'h100;
    #1;
    checks++; if (inst_req_ready !== 1'b1) begin failures++; $display("FAIL fetch_grant got=%0h exp=1", inst_req_ready); end
    checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL fetch_read_early got=%0h exp=0", mem_read); end
    @(negedge clk);
    inst_req_valid = 0; mem_req_ready = 1;
    #1;
    checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h100) begin failures++; $display("FAIL fetch_issue got=%0h/%h exp=1/00000100", mem_read, mem_addr); end
    @(negedge clk);
    mem_req_ready = 0; inst_rready = 1;
    #1;
    checks++; if (mem_read !== 1'b0 || inst_rvalid !== 1'b0) begin failures++; $display("FAIL fetch_rwait_idle got=%0h/%0h exp=0/0", mem_read, inst_rvalid); end
    @(negedge clk);
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (inst_rvalid !== 1'b1 || inst_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL fetch_resp got=%0h/%h exp=1/deadbeef", inst_rvalid, inst_rdata); end
    checks++; if (data_rvalid !== 1'b0) begin failures++; $display("FAIL fetch_data_rvalid got=%0h exp=0", data_rvalid); end
    checks++; if (mem_rready !== 1'b1) begin failures++; $display("FAIL fetch_rready got=%0h exp=1", mem_rready); end
    @(negedge clk);
    mem_rvalid = 0;
    #1;
    checks++; if (inst_rvalid !== 1'b0 || mem_rready !== 1'b0) begin failures++; $display("FAIL fetch_done got=%0h/%0h exp=0/0", inst_rvalid, mem_rready); end
  endtask

  task automatic test_store();
    do_reset();
    @(negedge clk);
    data_write = 1; data_addr = 32'h204; data_wdata = 32'h11223344; data_wstrb = 4'b1100;
    #1;
    checks++; if (data_req_ready !== 1'b1) begin failures++; $display("FAIL store_grant got=%0h exp=1", data_req_ready); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      data_write = 0; data_addr = 32'hFFFF; data_wdata = 32'h0; data_wstrb = 4'h0;
      mem_req_ready = (c == 3);
      #1;
      checks++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h204 ||
          mem_wdata !== 32'h11223344 || mem_wstrb !== 4'b1100) begin
        failures++;
        $display("FAIL store_hold_c%0d got=w%0h r%0h %h %h %b exp=w1 r0 00000204 11223344 1100",
                 c, mem_write, mem_read, mem_addr, mem_wdata, mem_wstrb);
      end
    end
    @(negedge clk);
    mem_req_ready = 0; inst_req_valid = 1; inst_addr = 32'h108;
    #1;
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL store_done got=%0h exp=0", mem_write); end
    checks++; if (inst_req_ready !== 1'b1) begin failures++; $display("FAIL store_b2b_grant got=%0h exp=1", inst_req_ready); end
    checks++; if ({inst_rvalid, data_rvalid} !== 2'b00) begin failures++; $display("FAIL store_no_resp got=%0b exp=00", {inst_rvalid, data_rvalid}); end
  endtask

  task automatic test_rw_wstrb0();
    do_reset();
    @(negedge clk);
    data_read = 1; data_write = 1; data_addr = 32'h300; data_wdata = 32'hA5A5A5A5; data_wstrb = 4'h0;
    #1;
    checks++; if (data_req_ready !== 1'b1) begin failures++; $display("FAIL rw_grant got=%0h exp=1", data_req_ready); end
    @(negedge clk);
    data_read = 0; data_write = 0; mem_req_ready = 1;
    #1;
    checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wstrb !== 4'h0) begin failures++; $display("FAIL rw_as_write got=w%0h r%0h %b exp=w1 r0 0000", mem_write, mem_read, mem_wstrb); end
    @(negedge clk);
    mem_req_ready = 0; mem_rvalid = 1; mem_rdata = 32'h12345678; data_rready = 1; inst_rready = 1;
    #1;
    checks++; if ({data_rvalid, inst_rvalid, mem_rready} !== 3'b000) begin failures++; $display("FAIL stray_rvalid got=%0b exp=000", {data_rvalid, inst_rvalid, mem_rready}); end
  endtask

  task automatic test_conflict_rr();
    do_reset();
    @(negedge clk);                                   // A
    inst_req_valid = 1; inst_addr = 32'h300;
    data_write = 1; data_addr = 32'h400; data_wdata = 32'h1; data_wstrb = 4'hF;
    #1;
    checks++; if ({data_req_ready, inst_req_ready} !== 2'b10) begin failures++; $display("FAIL rr_first_data got=%0b exp=10", {data_req_ready, inst_req_ready}); end
    @(negedge clk);                                   // B
    data_addr = 32'h404; mem_req_ready = 1;
    #1;
    checks++; if (mem_write !== 1'b1 || mem_addr !== 32'h400) begin failures++; $display("FAIL rr_first_issue got=%0h/%h exp=1/00000400", mem_write, mem_addr); end
    @(negedge clk);                                   // C
    mem_req_ready = 0;
    #1;
    checks++; if ({data_req_ready, inst_req_ready} !== 2'b01) begin failures++; $display("FAIL rr_second_inst got=%0b exp=01", {data_req_ready, inst_req_ready}); end
    @(negedge clk);                                   // D
    inst_addr = 32'h304; mem_req_ready = 1;
    #1;
    checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h300) begin failures++; $display("FAIL rr_second_issue got=%0h/%h exp=1/00000300", mem_read, mem_addr); end
    @(negedge clk);                                   // E
    mem_req_ready = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE0001; inst_rready = 1;
    #1;
    checks++; if (inst_rvalid !== 1'b1 || inst_rdata !== 32'hCAFE0001 || data_req_ready !== 1'b0) begin failures++; $display("FAIL rr_second_resp got=%0h/%h/%0h exp=1/cafe0001/0", inst_rvalid, inst_rdata, data_req_ready); end
    @(negedge clk);                                   // F
    mem_rvalid = 0;
    #1;
    checks++; if ({data_req_ready, inst_req_ready} !== 2'b10) begin failures++; $display("FAIL rr_third_data got=%0b exp=10", {data_req_ready, inst_req_ready}); end
    @(negedge clk);                                   // G
    inst_req_valid = 0; data_write = 0;
    #1;
    checks++; if (mem_write !== 1'b1 || mem_addr !== 32'h404) begin failures++; $display("FAIL rr_third_issue got=%0h/%h exp=1/00000404", mem_write, mem_addr); end
    checks++; if (conflict_cnt !== 32'd3) begin failures++; $display("FAIL rr_conflict_cnt got=%0d exp=3", conflict_cnt); end
  endtask

  task automatic test_conflict_fixed();
    do_reset();
    @(negedge clk);
    inst_req_valid = 1; inst_addr = 32'h300;
    data_write = 1; data_addr = 32'h400; data_wdata = 32'h2; data_wstrb = 4'hF;
    #1;
    checks++; if ({fx_data_req_ready, fx_inst_req_ready} !== 2'b10) begin failures++; $display("FAIL fx_first_data got=%0b exp=10", {fx_data_req_ready, fx_inst_req_ready}); end
    @(negedge clk);
    mem_req_ready = 1;
    #1;
    checks++; if (fx_mem_write !== 1'b1) begin failures++; $display("FAIL fx_first_issue got=%0h exp=1", fx_mem_write); end
    @(negedge clk);
    mem_req_ready = 0;
    #1;
    checks++; if ({fx_data_req_ready, fx_inst_req_ready} !== 2'b10) begin failures++; $display("FAIL fx_second_data got=%0b exp=10", {fx_data_req_ready, fx_inst_req_ready}); end
    @(negedge clk);
    inst_req_valid = 0; data_write = 0;
    #1;
    checks++; if (fx_conflict_cnt !== 32'd2) begin failures++; $display("FAIL fx_conflict_cnt got=%0d exp=2", fx_conflict_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    inst_req_valid = 1; inst_addr = 32'h120;
    @(negedge clk);
    inst_req_valid = 0; mem_req_ready = 1; data_read = 1; data_addr = 32'h600;
    @(negedge clk);
    mem_req_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0BADF00D; inst_rready = 0; data_rready = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (mem_rready !== 1'b0 || data_req_ready !== 1'b0 || inst_rvalid !== 1'b1 || data_rvalid !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_c%0d got=rr%0h dr%0h iv%0h dv%0h exp=rr0 dr0 iv1 dv0",
                 c, mem_rready, data_req_ready, inst_rvalid, data_rvalid);
      end
      @(negedge clk);
    end
    inst_rready = 1;
    #1;
    checks++; if (mem_rready !== 1'b1 || inst_rdata !== 32'h0BADF00D) begin failures++; $display("FAIL bp_release got=%0h/%h exp=1/0badf00d", mem_rready, inst_rdata); end
    @(negedge clk);
    mem_rvalid = 0; inst_rready = 0;
    #1;
    checks++; if (data_req_ready !== 1'b1) begin failures++; $display("FAIL bp_data_grant got=%0h exp=1", data_req_ready); end
  endtask

  task automatic test_reset_mid_rwait();
    do_reset();
    @(negedge clk);
    inst_req_valid = 1; inst_addr = 32'h500;
    @(negedge clk);
    inst_req_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0; mem_rvalid = 1; mem_rdata = 32'h55; inst_rready = 1;
    #1;
    checks++; if (inst_rvalid !== 1'b1) begin failures++; $display("FAIL mr_pre got=%0h exp=1", inst_rvalid); end
    #1;
    rst = 1'b0; inst_req_valid = 1;
    #1;
    checks++; if ({inst_rvalid, mem_rready, inst_req_ready, mem_read} !== 4'b0000 || inst_rdata !== 32'h0 || mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL mr_async got=%0b %h %h exp=0000 00000000 00000000", {inst_rvalid, mem_rready, inst_req_ready, mem_read}, inst_rdata, mem_addr);
    end
    @(negedge clk);
    rst = 1'b1; inst_req_valid = 0;
    #1;
    checks++; if ({inst_rvalid, data_rvalid, mem_rready} !== 3'b000) begin failures++; $display("FAIL mr_stray got=%0b exp=000", {inst_rvalid, data_rvalid, mem_rready}); end
    @(negedge clk);
    #1;
    checks++; if ({inst_rvalid, mem_rready, mem_read} !== 3'b000) begin failures++; $display("FAIL mr_stray2 got=%0b exp=000", {inst_rvalid, mem_rready, mem_read}); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    test_reset();
    test_fetch();
    test_store();
    test_rw_wstrb0();
    test_conflict_rr();
    test_conflict_fixed();
    test_backpressure();
    test_reset_mid_rwait();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
